// File: rtl/gcbp_encoder_if.sv
// Pixel-stream and BRAM-write bundle for the Gray-code bit-plane encoder.
// Combinational bundle only; the encoder owns all timing.
// No backpressure: the pixel source pushes and the BRAM write port always accepts.
interface gcbp_encoder_if;
  logic [8:0]   i_luma_data;
  logic         i_new_line;
  logic         i_luma_data_valid;
  logic [8:0]   i_line_cnt;
  logic         i_new_frame;
  logic [8:0]   o_bram_array_write_addr;
  logic [127:0] o_bram_array_write_data;
  logic [15:0]  o_bram_array_write_enable;
  logic [1:0]   o_next_frame_loc;
  logic [1:0]   o_curr_frame_loc;
  logic [1:0]   o_prev_frame_loc;

  // Pixel source / BRAM consumer side
  modport master (
    output i_luma_data, i_new_line, i_luma_data_valid, i_line_cnt, i_new_frame,
    input  o_bram_array_write_addr, o_bram_array_write_data, o_bram_array_write_enable,
    input  o_next_frame_loc, o_curr_frame_loc, o_prev_frame_loc
  );

  // Encoder side
  modport slave (
    input  i_luma_data, i_new_line, i_luma_data_valid, i_line_cnt, i_new_frame,
    output o_bram_array_write_addr, o_bram_array_write_data, o_bram_array_write_enable,
    output o_next_frame_loc, o_curr_frame_loc, o_prev_frame_loc
  );
endinterface

// File: rtl/gcbp_encoder.sv
// Gray-code bit-plane extractor: packs one plane of a 128-pixel line window into byte-lane BRAM writes.
// Latency: one clock from the pixel completing a byte to its write; frame slots rotate one clock after i_new_frame.
// No backpressure: every pixel is consumed on arrival; GCBP_FLUSH_EN also writes a partial byte on i_new_line.
module gcbp_encoder #(
  parameter int BIT_PLANE = 4,
  parameter int H_START   = 296
) (
  input  logic          i_clk,
  input  logic          i_resetn,
  gcbp_encoder_if.slave bus
);

  localparam logic [10:0] H_LO    = 11'(H_START);
  localparam logic [10:0] H_END   = 11'(H_START + 128);
  localparam logic [10:0] CNT_MAX = 11'h7FF;

  logic [10:0]  pix_cnt_q, pix_cnt_d;
  logic [7:0]   shift_q, shift_d;
  logic [8:0]   addr_q, addr_d;
  logic [127:0] data_q, data_d;
  logic [15:0]  en_q, en_d;
  logic [1:0]   next_q, next_d;
  logic [1:0]   curr_q, curr_d;
  logic [1:0]   prev_q, prev_d;

  logic [7:0]  luma;
  logic [7:0]  gray;
  logic        plane_bit;
  logic        luma_unused;
  logic [10:0] pix_idx;
  logic        in_win;
  logic [6:0]  win_idx;

  assign luma        = bus.i_luma_data[7:0];
  assign luma_unused = bus.i_luma_data[8];
  assign gray        = luma ^ (luma >> 1);
  assign plane_bit   = |(gray & (8'd1 << BIT_PLANE));

  // A new_line coinciding with a pixel makes that pixel index 0 of the new line.
  assign pix_idx = bus.i_new_line ? 11'd0 : pix_cnt_q;
  assign in_win  = bus.i_luma_data_valid && (pix_idx >= H_LO) && (pix_idx < H_END);
  assign win_idx = 7'(pix_idx - H_LO);

`ifdef GCBP_FLUSH_EN
  logic [8:0] line_q, line_d;
  logic [6:0] done_idx;
  logic [2:0] part_n;
  logic       part_pend;
  logic [7:0] part_byte;

  // pix_cnt_q counts pixels already seen, so its window offset gives bits captured so far.
  assign done_idx  = 7'(pix_cnt_q - H_LO);
  assign part_n    = done_idx[2:0];
  assign part_pend = bus.i_new_line && (pix_cnt_q > H_LO) && (pix_cnt_q < H_END) && (part_n != 3'd0);
  assign part_byte = shift_q << (4'd8 - {1'b0, part_n});

  // Remember the line of the last captured pixel so a flushed byte lands on its own line.
  always_comb begin
    line_d = line_q;
    if (in_win) line_d = bus.i_line_cnt;
  end

  // Line-number register for flushed partial bytes.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) line_q <= '0;
    else           line_q <= line_d;
  end
`endif

  // Pixel counting, bit-plane shifting, write generation and frame-slot rotation.
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    data_d    = data_q;
    en_d      = '0;
    next_d    = next_q;
    curr_d    = curr_q;
    prev_d    = prev_q;

    if (bus.i_new_line) begin
      pix_cnt_d = '0;
      shift_d   = '0;
    end

    if (bus.i_luma_data_valid) begin
      pix_cnt_d = (pix_idx == CNT_MAX) ? CNT_MAX : pix_idx + 11'd1;
    end

`ifdef GCBP_FLUSH_EN
    if (part_pend) begin
      addr_d = line_q;
      data_d = {16{part_byte}};
      en_d   = 16'd1 << done_idx[6:3];
    end
`endif

    if (in_win) begin
      shift_d = {shift_d[6:0], plane_bit};
      if (win_idx[2:0] == 3'd7) begin
        addr_d = bus.i_line_cnt;
        data_d = {16{shift_d}};
        en_d   = 16'd1 << win_idx[6:3];
      end
    end

    if (bus.i_new_frame) begin
      next_d = prev_q;
      curr_d = next_q;
      prev_d = curr_q;
    end
  end

  // State and output registers; synchronous reset restores the initial slot order.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      pix_cnt_q <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      en_q      <= '0;
      next_q    <= 2'd0;
      curr_q    <= 2'd2;
      prev_q    <= 2'd1;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      en_q      <= en_d;
      next_q    <= next_d;
      curr_q    <= curr_d;
      prev_q    <= prev_d;
    end
  end

  assign bus.o_bram_array_write_addr   = addr_q;
  assign bus.o_bram_array_write_data   = data_q;
  assign bus.o_bram_array_write_enable = en_q;
  assign bus.o_next_frame_loc          = next_q;
  assign bus.o_curr_frame_loc          = curr_q;
  assign bus.o_prev_frame_loc          = prev_q;

endmodule

// File: tb/tb_gcbp_encoder.sv
// Self-checking bench for gcbp_encoder: directed line/frame/reset steps with a write scoreboard.
// Expected writes are queued when the completing pixel is driven and compared at the output.
// The monitor also checks reset values, hold behaviour and exact write cycle.
module tb_gcbp_encoder;
  localparam int H = 296;

  logic clk = 1'b0;
  logic resetn;

  gcbp_encoder_if bus ();

  gcbp_encoder #(.BIT_PLANE(4), .H_START(H)) dut (
    .i_clk    (clk),
    .i_resetn (resetn),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]   addr;
    logic [127:0] data;
    logic [15:0]  en;
    int           due;
  } wr_t;

  wr_t sb[$];

  int   tests   = 0;
  int   fails   = 0;
  int   neg_cyc = 0;
  bit   mon_en  = 1'b0;
  logic rst_q;

  logic [8:0]   last_addr = '0;
  logic [127:0] last_data = '0;

  int         m_pix  = 0;
  int         m_cnt  = 0;
  int         m_lane = 0;
  logic [7:0] m_acc  = '0;
  logic [8:0] m_line = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic plane(input logic [7:0] y);
    logic [7:0] g;
    g = y ^ (y >> 1);
    return g[4];
  endfunction

  // Driven after posedge k; sampled at posedge k+1; seen at the second following negedge.
  task automatic push_wr(input logic [8:0] a, input logic [7:0] b, input int lane);
    wr_t e;
    e.addr = a;
    e.data = {16{b}};
    e.en   = 16'd1 << lane;
    e.due  = neg_cyc + 2;
    sb.push_back(e);
  endtask

  task automatic model_nl();
`ifdef GCBP_FLUSH_EN
    if (m_cnt > 0) push_wr(m_line, m_acc << (8 - m_cnt), m_lane);
`endif
    m_pix = 0;
    m_cnt = 0;
    m_acc = '0;
  endtask

  task automatic clear_pulses();
    bus.i_luma_data_valid = 1'b0;
    bus.i_new_line        = 1'b0;
    bus.i_new_frame       = 1'b0;
  endtask

  task automatic pix(input logic [8:0] y, input logic [8:0] ln, input bit nl);
    @(posedge clk); #1;
    bus.i_luma_data       = y;
    bus.i_luma_data_valid = 1'b1;
    bus.i_new_line        = nl;
    bus.i_line_cnt        = ln;
    bus.i_new_frame       = 1'b0;
    if (nl) model_nl();
    if (m_pix >= H && m_pix < H + 128) begin
      m_acc  = {m_acc[6:0], plane(y[7:0])};
      m_cnt++;
      m_line = ln;
      m_lane = (m_pix - H) / 8;
      if ((m_pix - H) % 8 == 7) begin
        push_wr(ln, m_acc, m_lane);
        m_cnt = 0;
      end
    end
    if (m_pix < 2047) m_pix++;
  endtask

  task automatic nl_only(input logic [8:0] ln);
    @(posedge clk); #1;
    clear_pulses();
    bus.i_new_line = 1'b1;
    bus.i_line_cnt = ln;
    model_nl();
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    clear_pulses();
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_line(input logic [8:0] ln, input int n, input logic [8:0] y, input bit rnd, input bit comb);
    if (!comb) nl_only(ln);
    for (int i = 0; i < n; i++) pix(rnd ? 9'($urandom) : y, ln, comb && (i == 0));
  endtask

  task automatic chk_slots(input string tag, input logic [1:0] n, input logic [1:0] c, input logic [1:0] p);
    chk({tag, "_next"}, bus.o_next_frame_loc, n);
    chk({tag, "_curr"}, bus.o_curr_frame_loc, c);
    chk({tag, "_prev"}, bus.o_prev_frame_loc, p);
  endtask

  task automatic frame();
    @(posedge clk); #1;
    clear_pulses();
    bus.i_new_frame = 1'b1;
    @(posedge clk); #1;
    bus.i_new_frame = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    clear_pulses();
    sb.delete();
    m_pix = 0;
    m_cnt = 0;
    m_acc = '0;
    @(posedge clk); #1;
    chk_slots("midrst", 2'd0, 2'd2, 2'd1);
    chk("midrst_en", bus.o_bram_array_write_enable, 16'h0);
    chk("midrst_data", bus.o_bram_array_write_data, 128'h0);
    resetn = 1'b1;
  endtask

  always @(posedge clk) rst_q <= resetn;

  // Output monitor: reset values, scoreboard compare with exact cycle, hold while idle.
  always @(negedge clk) begin : mon
    wr_t e;
    if (mon_en) begin
      neg_cyc++;
      if (!rst_q) begin
        chk("rst_addr", bus.o_bram_array_write_addr, 9'd0);
        chk("rst_data", bus.o_bram_array_write_data, 128'h0);
        chk("rst_en", bus.o_bram_array_write_enable, 16'h0);
        last_addr = '0;
        last_data = '0;
      end else if (bus.o_bram_array_write_enable !== 16'h0) begin
        tests++;
        assert (sb.size() > 0) else begin
          fails++;
          $error("FAIL unexpected_write observed en=%0h addr=%0d expected no write",
                 bus.o_bram_array_write_enable, bus.o_bram_array_write_addr);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("wr_addr", bus.o_bram_array_write_addr, e.addr);
          chk("wr_data", bus.o_bram_array_write_data, e.data);
          chk("wr_en", bus.o_bram_array_write_enable, e.en);
          chk("wr_cycle", neg_cyc, e.due);
        end
        last_addr = bus.o_bram_array_write_addr;
        last_data = bus.o_bram_array_write_data;
      end else begin
        chk("hold_addr", bus.o_bram_array_write_addr, last_addr);
        chk("hold_data", bus.o_bram_array_write_data, last_data);
        if (sb.size() > 0) begin
          chk("missed_write_overdue", (sb[0].due <= neg_cyc) ? 1 : 0, 0);
          if (sb[0].due <= neg_cyc) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    resetn          = 1'b0;
    bus.i_luma_data = '0;
    bus.i_line_cnt  = '0;
    clear_pulses();
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    chk_slots("reset", 2'd0, 2'd2, 2'd1);
    chk("reset_en", bus.o_bram_array_write_enable, 16'h0);
    chk("reset_addr", bus.o_bram_array_write_addr, 9'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(3);

    // Bright line: plane bit 1 everywhere, 16 lane-ordered writes to line 5.
    run_line(9'd5, 424, 9'h010, 1'b0, 1'b0);
    idle(3);
    chk("line5_drained", sb.size(), 0);

    // Plane bit 0 everywhere.
    run_line(9'd6, 424, 9'h030, 1'b0, 1'b0);
    idle(3);
    chk("line6_drained", sb.size(), 0);

    // Frame slot rotation.
    frame();
    chk_slots("frame1", 2'd1, 2'd0, 2'd2);
    frame();
    chk_slots("frame2", 2'd2, 2'd1, 2'd0);
    frame();
    chk_slots("frame3", 2'd0, 2'd2, 2'd1);

    // Partial line, then new_line coinciding with the first pixel of a random line.
    run_line(9'd7, 350, 9'h000, 1'b1, 1'b0);
    run_line(9'd8, 424, 9'h000, 1'b1, 1'b1);
    idle(3);
    chk("combined_drained", sb.size(), 0);

    // Long line: counter must saturate rather than wrap back into the window.
    run_line(9'd9, 2500, 9'h000, 1'b1, 1'b0);
    idle(3);
    chk("saturate_drained", sb.size(), 0);

    // Partial byte at line end: flushed as 0xF0 on lane 0 only when the flush build is used.
    run_line(9'd10, 300, 9'h010, 1'b0, 1'b0);
    nl_only(9'd11);
    idle(4);
    chk("partial_drained", sb.size(), 0);

    // Reset mid-line discards the partial byte and restores the slots.
    frame();
    chk_slots("prerst", 2'd1, 2'd0, 2'd2);
    run_line(9'd12, 300, 9'h010, 1'b0, 1'b0);
    do_reset();
    run_line(9'd13, 424, 9'h010, 1'b0, 1'b0);
    idle(3);
    chk("postrst_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
